// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master transfer sequencer.
package spi_pkg;

  localparam int unsigned DataWidthDef = 8;
  // SCK edges per transfer at the default data width
  localparam int unsigned EdgeCount = 16;

  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StLead  = 4'b0010,
    StShift = 4'b0100,
    StTrail = 4'b1000
  } state_e;

endpackage

// File: rtl/spi_baud_gen.sv
// Half-period tick generator: H = (sppr+1) << spr clocks, restarted by load_i.
module spi_baud_gen #(
  parameter int unsigned DIV_WIDTH = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] sppr_i,
  input  logic [2:0] spr_i,
  input  logic       load_i,
  input  logic       run_i,
  output logic       tick_o
);

  logic [DIV_WIDTH-1:0] h_m1;
  logic [DIV_WIDTH-1:0] reload_q, reload_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  // (sppr+1)<<spr - 1 rearranged so no intermediate exceeds DIV_WIDTH bits
  always_comb begin
    h_m1 = (DIV_WIDTH'(sppr_i) << spr_i) + ((DIV_WIDTH'(1) << spr_i) - DIV_WIDTH'(1));
  end

  always_comb begin
    reload_d = reload_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      reload_d = h_m1;
      cnt_d    = h_m1;
    end else if (run_i) begin
      cnt_d = (cnt_q == '0) ? reload_q : cnt_q - DIV_WIDTH'(1);
    end
  end

  assign tick_o = run_i && !load_i && (cnt_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reload_q <= '0;
      cnt_q    <= '0;
    end else begin
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: single-entry TX buffer, SS/SCK sequencing, SPIF/SPTEF/OVRF.
// Define SPI_XFER_CTRL_LSBFE_EN to add the lsbfe_in port and LSB-first transfers.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidthDef,
  parameter int unsigned DIV_WIDTH  = 10
) (
  input  logic                  apb_clk_in,
  input  logic                  apb_rst_in,
  input  logic                  spe_in,
  input  logic                  cpol_in,
  input  logic                  cpha_in,
`ifdef SPI_XFER_CTRL_LSBFE_EN
  input  logic                  lsbfe_in,
`endif
  input  logic [2:0]            sppr_in,
  input  logic [2:0]            spr_in,
  input  logic                  dr_wr_in,
  input  logic [DATA_WIDTH-1:0] dr_wdata_in,
  input  logic                  dr_rd_in,
  input  logic                  miso_in,
  output logic                  sck_out,
  output logic                  mosi_out,
  output logic                  ss_n_out,
  output logic [DATA_WIDTH-1:0] rx_data_out,
  output logic                  spif_out,
  output logic                  sptef_out,
  output logic                  ovrf_out,
  output logic                  busy_out
);

  localparam int unsigned Edges = EdgeCount * DATA_WIDTH / DataWidthDef;
  localparam int unsigned EdgeW = $clog2(Edges + 1);

  state_e                state_q, state_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic                  sptef_q, sptef_d;
  logic                  spif_q, spif_d;
  logic                  ovrf_q, ovrf_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic [EdgeW-1:0]      edge_q, edge_d;

  logic baud_load, baud_tick, do_edge, sample_edge, trail_entry;
  logic lsb_first, lsb_new;

`ifdef SPI_XFER_CTRL_LSBFE_EN
  logic lsbfe_q, lsbfe_d;
  assign lsb_first = lsbfe_q;
  assign lsb_new   = lsbfe_in;
`else
  assign lsb_first = 1'b0;
  assign lsb_new   = 1'b0;
`endif

  spi_baud_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud (
    .clk_i (apb_clk_in),
    .rst_i (apb_rst_in),
    .sppr_i(sppr_in),
    .spr_i (spr_in),
    .load_i(baud_load),
    .run_i (state_q != StIdle),
    .tick_o(baud_tick)
  );

  // edge_q counts edges already issued, so the upcoming edge is odd when edge_q is even
  assign sample_edge = cpha_q ? edge_q[0] : ~edge_q[0];

  always_comb begin
    state_d     = state_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    sh_d        = sh_q;
    buf_d       = buf_q;
    rx_d        = rx_q;
    sptef_d     = sptef_q;
    spif_d      = spif_q;
    ovrf_d      = ovrf_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    edge_d      = edge_q;
    baud_load   = 1'b0;
    do_edge     = 1'b0;
    trail_entry = 1'b0;
`ifdef SPI_XFER_CTRL_LSBFE_EN
    lsbfe_d     = lsbfe_q;
`endif

    if (dr_rd_in) begin
      spif_d = 1'b0;
      ovrf_d = 1'b0;
    end
    if (dr_wr_in && sptef_q) begin
      buf_d   = dr_wdata_in;
      sptef_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        sck_d = cpol_in;
        if (spe_in && !sptef_q) begin
          state_d   = StLead;
          baud_load = 1'b1;
          cpol_d    = cpol_in;
          cpha_d    = cpha_in;
`ifdef SPI_XFER_CTRL_LSBFE_EN
          lsbfe_d   = lsbfe_in;
`endif
          sh_d      = buf_q;
          sptef_d   = 1'b1;
          edge_d    = '0;
          if (!cpha_in) begin
            mosi_d = lsb_new ? buf_q[0] : buf_q[DATA_WIDTH-1];
          end
        end
      end
      StLead: begin
        sck_d = cpol_q;
        if (baud_tick) begin
          state_d = StShift;
          do_edge = 1'b1;
        end
      end
      StShift: begin
        if (baud_tick) begin
          if (edge_q == EdgeW'(Edges)) begin
            state_d     = StTrail;
            trail_entry = 1'b1;
          end else begin
            do_edge = 1'b1;
          end
        end
      end
      StTrail: begin
        sck_d = cpol_q;
        if (baud_tick) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // One shift register serves both directions: MOSI leaves the top, MISO enters the bottom
    if (do_edge) begin
      sck_d  = ~sck_q;
      edge_d = edge_q + EdgeW'(1);
      if (sample_edge) begin
        sh_d = lsb_first ? {miso_in, sh_q[DATA_WIDTH-1:1]} : {sh_q[DATA_WIDTH-2:0], miso_in};
      end else begin
        mosi_d = lsb_first ? sh_q[0] : sh_q[DATA_WIDTH-1];
      end
    end

    if ((state_q != StIdle) && !spe_in) begin
      state_d     = StIdle;
      sck_d       = cpol_in;
      sptef_d     = 1'b1;
      buf_d       = '0;
      trail_entry = 1'b0;
    end

    // Evaluated after the read clear so a coincident read avoids the overrun
    if (trail_entry) begin
      if (!spif_d) begin
        rx_d   = sh_q;
        spif_d = 1'b1;
      end else begin
        ovrf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
    if (apb_rst_in) begin
      state_q <= StIdle;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      sh_q    <= '0;
      buf_q   <= '0;
      rx_q    <= '0;
      sptef_q <= 1'b1;
      spif_q  <= 1'b0;
      ovrf_q  <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      edge_q  <= '0;
    end else begin
      state_q <= state_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      sh_q    <= sh_d;
      buf_q   <= buf_d;
      rx_q    <= rx_d;
      sptef_q <= sptef_d;
      spif_q  <= spif_d;
      ovrf_q  <= ovrf_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      edge_q  <= edge_d;
    end
  end

`ifdef SPI_XFER_CTRL_LSBFE_EN
  always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
    if (apb_rst_in) begin
      lsbfe_q <= 1'b0;
    end else begin
      lsbfe_q <= lsbfe_d;
    end
  end
`endif

  assign sck_out     = sck_q;
  assign mosi_out    = mosi_q;
  assign ss_n_out    = (state_q == StIdle);
  assign rx_data_out = rx_q;
  assign spif_out    = spif_q;
  assign sptef_out   = sptef_q;
  assign ovrf_out    = ovrf_q;
  assign busy_out    = (state_q != StIdle);

endmodule
